// File: rtl/ma_window_ctrl.sv
// Moving-average window sequencer: owns the window exponent, flushes the
// averager on start or window change, gates samples in, tracks fill and
// flags when the averager output is valid.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | halted, averager untouched, waiting for i_start
// S_FLUSH | o_ma_clr held for FLUSH_CYC cycles, incoming samples dropped
// S_FILL  | samples accepted, window not yet fully populated
// S_RUN   | window populated, o_dout_vld follows accepted samples by 1 cycle
module ma_window_ctrl #(
   parameter int MAX_LOG2  = 6,
   parameter int DEF_LOG2  = 3,
   parameter int FLUSH_CYC = 2,
   parameter int CW        = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [CW-1:0] i_win_log2,
   input  logic          i_cfg_wr,
   input  logic          i_start,
   input  logic          i_stop,
   input  logic          i_din_vld,
   output logic          o_ma_clr,
   output logic          o_ma_en,
   output logic [CW-1:0] o_win_log2,
   output logic          o_dout_vld,
   output logic [1:0]    o_state,
   output logic          o_cfg_err,
   output logic [15:0]   o_drop_cnt
);

   localparam int FW  = MAX_LOG2 + 1;
   localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FLUSH = 2'd1,
      S_FILL  = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_win;
   logic [FCW-1:0]  r_flush_cnt;
   logic [FW-1:0]   r_fill_cnt;
   logic            r_ma_clr;
   logic            r_ma_en;
   logic            r_dout_vld;
   logic            r_cfg_err;
   logic [15:0]     r_drop_cnt;

   logic            w_cfg_ok;
   logic            w_cfg_bad;
   logic            w_active;
   logic            w_restart;
   logic            w_accept;
   logic [FW-1:0]   w_fill_target;
   logic            w_fill_last;
   logic            w_flush_done;
   logic            w_start_go;
   logic            w_drop;

   // Request qualification; stop beats a restart, a restart beats a sample.
   assign w_cfg_ok      = i_cfg_wr && (int'(i_win_log2) <= MAX_LOG2);
   assign w_cfg_bad     = i_cfg_wr && !w_cfg_ok;
   assign w_active      = (r_state == S_FILL) || (r_state == S_RUN);
   assign w_restart     = w_cfg_ok && w_active && !i_stop;
   assign w_accept      = w_active && i_din_vld && !i_stop && !w_restart;
   assign w_fill_target = FW'(1) << r_win;
   assign w_fill_last   = (r_state == S_FILL) && w_accept &&
                          ((r_fill_cnt + FW'(1)) == w_fill_target);
   assign w_flush_done  = (r_state == S_FLUSH) && (r_flush_cnt == '0);
   assign w_start_go    = (r_state == S_IDLE) && i_start && !i_stop;
   assign w_drop        = (r_state == S_FLUSH) && i_din_vld && !i_stop;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      if (i_stop) begin
         w_state_nxt = S_IDLE;
      end else if (w_restart) begin
         w_state_nxt = S_FLUSH;
      end else begin
         case (r_state)
            S_IDLE:  if (i_start)      w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_flush_done) w_state_nxt = S_FILL;
            S_FILL:  if (w_fill_last)  w_state_nxt = S_RUN;
            S_RUN:                     w_state_nxt = S_RUN;
            default:                   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Flush down-counter (loaded on FLUSH entry) and fill up-counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flush_cnt <= '0;
         r_fill_cnt  <= '0;
      end else begin
         if (w_state_nxt == S_FLUSH && (r_state != S_FLUSH || w_restart))
            r_flush_cnt <= FCW'(FLUSH_CYC - 1);
         else if (r_state == S_FLUSH && r_flush_cnt != '0)
            r_flush_cnt <= r_flush_cnt - FCW'(1);

         if (r_state != S_FILL)
            r_fill_cnt <= '0;
         else if (w_accept)
            r_fill_cnt <= r_fill_cnt + FW'(1);
      end
   end

   // Registered outputs, window register and saturating drop counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_win      <= CW'(DEF_LOG2);
         r_ma_clr   <= 1'b0;
         r_ma_en    <= 1'b0;
         r_dout_vld <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_cfg_ok) r_win <= i_win_log2;
         r_ma_clr   <= (w_state_nxt == S_FLUSH);
         r_ma_en    <= w_accept;
         r_dout_vld <= w_accept && ((r_state == S_RUN) || w_fill_last);
         r_cfg_err  <= w_cfg_bad;
         if (w_start_go)
            r_drop_cnt <= '0;
         else if (w_drop && r_drop_cnt != 16'hFFFF)
            r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign o_ma_clr   = r_ma_clr;
   assign o_ma_en    = r_ma_en;
   assign o_win_log2 = r_win;
   assign o_dout_vld = r_dout_vld;
   assign o_state    = r_state;
   assign o_cfg_err  = r_cfg_err;
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ma_window_ctrl.sv
// Bench for ma_window_ctrl: expected o_dout_vld / o_cfg_err cycles are
// queued by the stimulus and consumed by a monitor on the falling edge.
module tb_ma_window_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  win_log2;
   logic        cfg_wr, start, stop, din_vld;
   logic        ma_clr, ma_en, dout_vld, cfg_err;
   logic [2:0]  win_out;
   logic [1:0]  state;
   logic [15:0] drop_cnt;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int q_vld[$];
   int q_err[$];
   int s, r, t, e;

   ma_window_ctrl dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_win_log2 (win_log2),
      .i_cfg_wr   (cfg_wr),
      .i_start    (start),
      .i_stop     (stop),
      .i_din_vld  (din_vld),
      .o_ma_clr   (ma_clr),
      .o_ma_en    (ma_en),
      .o_win_log2 (win_out),
      .o_dout_vld (dout_vld),
      .o_state    (state),
      .o_cfg_err  (cfg_err),
      .o_drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: match every strobe the DUT presents against the queued cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (q_vld.size() > 0 && q_vld[0] < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL dout_vld_missing: got none expected cycle %0d", q_vld.pop_front());
         end
         if (dout_vld) begin
            if (q_vld.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL dout_vld_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else chk("dout_vld_cycle", cyc, q_vld.pop_front());
         end
         while (q_err.size() > 0 && q_err[0] < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL cfg_err_missing: got none expected cycle %0d", q_err.pop_front());
         end
         if (cfg_err) begin
            if (q_err.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL cfg_err_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else chk("cfg_err_cycle", cyc, q_err.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; win_log2 = '0; cfg_wr = 0; start = 0; stop = 0; din_vld = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_win", win_out, 3);
      chk("rst_clr", ma_clr, 0);
      chk("rst_en", ma_en, 0);
      chk("rst_dout", dout_vld, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;
      tick(); tick();
      chk("idle_state", state, 0);

      // window 16, continuous samples with a 2-cycle gap in RUN
      cfg_wr = 1; win_log2 = 3'd4; tick(); cfg_wr = 0;
      chk("cfg4_win", win_out, 4);
      s = cyc;
      for (int k = 19; k <= 22; k++) q_vld.push_back(s + k);
      for (int k = 25; k <= 32; k++) q_vld.push_back(s + k);
      start = 1; tick(); start = 0;
      for (int i = 1; i <= 31; i++) begin
         chk("w16_state", state, (i <= 2) ? 1 : (i <= 18) ? 2 : 3);
         chk("w16_clr", ma_clr, (i <= 2) ? 1 : 0);
         chk("w16_en", ma_en, (i >= 4 && i != 23 && i != 24) ? 1 : 0);
         if (i == 3) chk("w16_drop", drop_cnt, 2);
         din_vld = (i == 22 || i == 23) ? 1'b0 : 1'b1;
         tick();
      end
      din_vld = 0;
      chk("w16_run", state, 3);

      // out-of-range window request
      e = cyc; q_err.push_back(e + 1);
      cfg_wr = 1; win_log2 = 3'd7; tick(); cfg_wr = 0;
      chk("bad_win_kept", win_out, 4);
      chk("bad_state", state, 3);
      tick();
      chk("bad_err_pulse_end", cfg_err, 0);

      // window change in RUN forces a refill with 4 samples
      r = cyc;
      q_vld.push_back(r + 7); q_vld.push_back(r + 8); q_vld.push_back(r + 9);
      cfg_wr = 1; win_log2 = 3'd2; din_vld = 1; tick(); cfg_wr = 0;
      for (int i = 1; i <= 9; i++) begin
         chk("w4_state", state, (i <= 2) ? 1 : (i <= 6) ? 2 : 3);
         chk("w4_clr", ma_clr, (i <= 2) ? 1 : 0);
         if (i == 1) chk("w4_win", win_out, 2);
         if (i == 3) chk("w4_drop", drop_cnt, 4);
         din_vld = (i <= 8) ? 1'b1 : 1'b0;
         tick();
      end
      din_vld = 0;

      stop = 1; tick(); stop = 0;
      chk("stop_state", state, 0);
      chk("stop_en", ma_en, 0);

      // stop together with a config write while filling
      start = 1; tick(); start = 0; tick(); tick();
      chk("sc_fill", state, 2);
      chk("sc_drop_cleared", drop_cnt, 0);
      tick();
      stop = 1; cfg_wr = 1; win_log2 = 3'd5; din_vld = 1; tick();
      stop = 0; cfg_wr = 0; din_vld = 0;
      chk("sc_state", state, 0);
      chk("sc_win", win_out, 5);
      chk("sc_clr", ma_clr, 0);
      chk("sc_en", ma_en, 0);
      tick();
      chk("sc_clr2", ma_clr, 0);

      // window of one sample, then async reset while running
      cfg_wr = 1; win_log2 = 3'd0; tick(); cfg_wr = 0;
      chk("w1_win", win_out, 0);
      t = cyc;
      q_vld.push_back(t + 4); q_vld.push_back(t + 5); q_vld.push_back(t + 6);
      start = 1; tick(); start = 0; din_vld = 1;
      tick(); tick();
      chk("w1_fill", state, 2);
      chk("w1_drop", drop_cnt, 2);
      tick();
      chk("w1_run", state, 3);
      tick(); tick();
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      chk("arst_state", state, 0);
      chk("arst_win", win_out, 3);
      chk("arst_en", ma_en, 0);
      chk("arst_dout", dout_vld, 0);
      chk("arst_drop", drop_cnt, 0);
      din_vld = 0;
      #3 rst_n = 1'b1;
      tick(); tick();
      chk("vld_queue_empty", q_vld.size(), 0);
      chk("err_queue_empty", q_err.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
